// File: rtl/spi_txn_controller_if.sv
// Bus bundle between the SPI transaction sequencer and its surroundings:
// conditioned SCLK/CS inputs and shift-register contents in, memory
// address plus shift-register / data-memory / MISO-buffer strobes out.
interface spi_txn_controller_if #(
    parameter int ADDR_W = 7
);
    logic              sclk_posedge;
    logic              cs;
    logic [7:0]        sr_pout;
    logic [ADDR_W-1:0] addr;
    logic              sr_we;
    logic              dm_we;
    logic              miso_bufe;
    logic [3:0]        state_dbg;

    // Sequencer side
    modport slave (
        input  sclk_posedge,
        input  cs,
        input  sr_pout,
        output addr,
        output sr_we,
        output dm_we,
        output miso_bufe,
        output state_dbg
    );

    // Environment side (SCLK conditioner, shift register, memory)
    modport master (
        output sclk_posedge,
        output cs,
        output sr_pout,
        input  addr,
        input  sr_we,
        input  dm_we,
        input  miso_bufe,
        input  state_dbg
    );
endinterface

// File: rtl/spi_txn_controller.sv
// SPI memory-slave transaction sequencer.
// Counts SCLK rising edges inside a chip-select window, decodes the
// address/R-W byte, owns the memory address register and drives the
// shift-register load, data-memory write and MISO-enable strobes.
// Optional feature macro: SPI_BURST_EN -- when defined, consecutive data
// bytes stream to/from incrementing addresses until chip select rises;
// when undefined, one data byte per chip-select window.
module spi_txn_controller #(
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    spi_txn_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        DECODE      = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [2:0]        r_bitCnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_srWe;
    logic              r_dmWe;
    logic              r_misoBufe;
    logic              w_counting;
    logic              w_lastBit;

    // Only the three shifting phases count SCLK edges; the edge that wraps
    // the counter from 7 back to 0 closes the current byte.
    assign w_counting = (r_state == GET_ADDR) || (r_state == READ_SHIFT) ||
                        (r_state == WRITE_GET);
    assign w_lastBit  = w_counting && bus.sclk_posedge && (r_bitCnt == 3'd7);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a high chip select aborts everything, even a pending store
    always_comb begin
        w_nextState = r_state;
        if (bus.cs) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:        w_nextState = GET_ADDR;
                GET_ADDR:    if (w_lastBit) w_nextState = DECODE;
                DECODE:      w_nextState = bus.sr_pout[0] ? READ_LOAD : WRITE_GET;
                READ_LOAD:   w_nextState = READ_SHIFT;
`ifdef SPI_BURST_EN
                READ_SHIFT:  if (w_lastBit) w_nextState = READ_LOAD;
                WRITE_STORE: w_nextState = WRITE_GET;
`else
                READ_SHIFT:  if (w_lastBit) w_nextState = DONE;
                WRITE_STORE: w_nextState = DONE;
`endif
                WRITE_GET:   if (w_lastBit) w_nextState = WRITE_STORE;
                DONE:        w_nextState = DONE;
                default:     w_nextState = IDLE;
            endcase
        end
    end

    // Bit counter: cleared outside a live window, advanced only while shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt <= 3'd0;
        end else if (bus.cs || (r_state == IDLE)) begin
            r_bitCnt <= 3'd0;
        end else if (w_counting && bus.sclk_posedge) begin
            r_bitCnt <= r_bitCnt + 3'd1;
        end
    end

    // Address register: captured from the address byte, bumped between burst bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (!bus.cs) begin
            if (r_state == DECODE) begin
                r_addr <= bus.sr_pout[ADDR_W:1];
`ifdef SPI_BURST_EN
            end else if ((r_state == READ_SHIFT) && w_lastBit) begin
                r_addr <= r_addr + 1'b1;
            end else if (r_state == WRITE_STORE) begin
                r_addr <= r_addr + 1'b1;
`endif
            end
        end
    end

    // Strobes are flops keyed off the next state so they line up exactly with the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_srWe     <= 1'b0;
            r_dmWe     <= 1'b0;
            r_misoBufe <= 1'b0;
        end else begin
            r_srWe     <= (w_nextState == READ_LOAD);
            r_dmWe     <= (w_nextState == WRITE_STORE);
            r_misoBufe <= (w_nextState == READ_LOAD) || (w_nextState == READ_SHIFT);
        end
    end

    assign bus.addr      = r_addr;
    assign bus.sr_we     = r_srWe;
    assign bus.dm_we     = r_dmWe;
    assign bus.miso_bufe = r_misoBufe;
    assign bus.state_dbg = {1'b0, r_state};

endmodule

// File: tb/tb_spi_txn_controller.sv
// Directed bench for spi_txn_controller: models the SCLK conditioner,
// shift register and data memory around the sequencer, scoreboards the
// dm_we / sr_we strobes and checks state, address and MISO data.
// Honours SPI_BURST_EN for the burst-dependent expectations.
module tb_spi_txn_controller;

    typedef struct {
        bit         isWrite;
        logic [6:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       clk;
    logic       reset;
    logic [7:0] srModel;
    logic [7:0] mem [0:127];
    logic [7:0] loadedByte;
    logic [7:0] misoByte;
    int         testCount;
    int         failCount;
    strobe_t    expQ[$];

    spi_txn_controller_if #(.ADDR_W(7)) bus ();

    spi_txn_controller #(.ADDR_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: written by dm_we, cleared on reset
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (bus.dm_we) begin
            mem[bus.addr] <= bus.sr_pout;
        end
    end

    // Shift-register parallel load model: the byte that will go out on MISO
    always @(posedge clk) begin
        if (reset) loadedByte <= 8'h00;
        else if (bus.sr_we) loadedByte <= mem[bus.addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe cycle must match the oldest pending expectation
    always @(negedge clk) begin
        strobe_t e;
        if (!reset && (bus.dm_we || bus.sr_we)) begin
            checkOutput("sbPending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("sbKind", 32'(bus.dm_we), 32'(e.isWrite));
                checkOutput("sbAddr", 32'(bus.addr), 32'(e.addr));
                if (e.isWrite) checkOutput("sbWrData", 32'(bus.sr_pout), 32'(e.data));
                else           checkOutput("sbRdData", 32'(mem[bus.addr]), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conditioned SCLK rising edge, at least 3 clk after the previous one
    task automatic applyStimulus(input bit mosiBit);
        repeat (3) tick();
        srModel          = {srModel[6:0], mosiBit};
        bus.sr_pout      = srModel;
        bus.sclk_posedge = 1'b1;
        tick();
        bus.sclk_posedge = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyStimulus(b[i]);
    endtask

    task automatic pushExp(input bit w, input logic [6:0] a, input logic [7:0] d);
        strobe_t e;
        e.isWrite = w;
        e.addr    = a;
        e.data    = d;
        expQ.push_back(e);
    endtask

    initial begin
        logic [7:0] pat;
        testCount        = 0;
        failCount        = 0;
        reset            = 1'b1;
        bus.cs           = 1'b1;
        bus.sclk_posedge = 1'b0;
        bus.sr_pout      = 8'h00;
        srModel          = 8'h00;
        misoByte         = 8'h00;

        // Reset state
        repeat (2) tick();
        checkOutput("rstState", 32'(bus.state_dbg), 32'd0);
        checkOutput("rstAddr",  32'(bus.addr), 32'd0);
        checkOutput("rstSrWe",  32'(bus.sr_we), 32'd0);
        checkOutput("rstDmWe",  32'(bus.dm_we), 32'd0);
        checkOutput("rstBufe",  32'(bus.miso_bufe), 32'd0);
        bus.cs = 1'b0;
        tick();
        checkOutput("holdInReset", 32'(bus.state_dbg), 32'd0);
        bus.cs = 1'b1;
        reset  = 1'b0;
        repeat (2) tick();

        // Write 0xC3 to 0x2A
        bus.cs = 1'b0;
        tick();
        checkOutput("wrCsFall", 32'(bus.state_dbg), 32'd1);
        sendByte(8'h54);
        checkOutput("wrDecode", 32'(bus.state_dbg), 32'd2);
        tick();
        checkOutput("wrGetState", 32'(bus.state_dbg), 32'd5);
        checkOutput("wrGetAddr",  32'(bus.addr), 32'h2A);
        pushExp(1'b1, 7'h2A, 8'hC3);
        sendByte(8'hC3);
        checkOutput("wrStoreState", 32'(bus.state_dbg), 32'd6);
        checkOutput("wrStoreDmWe",  32'(bus.dm_we), 32'd1);
        checkOutput("wrStoreAddr",  32'(bus.addr), 32'h2A);
        tick();
        checkOutput("wrAfterDmWe", 32'(bus.dm_we), 32'd0);
`ifdef SPI_BURST_EN
        checkOutput("wrAfterState", 32'(bus.state_dbg), 32'd5);
        checkOutput("wrAfterAddr",  32'(bus.addr), 32'h2B);
`else
        checkOutput("wrAfterState", 32'(bus.state_dbg), 32'd7);
        checkOutput("wrAfterAddr",  32'(bus.addr), 32'h2A);
`endif
        bus.cs = 1'b1;
        tick();
        checkOutput("wrCsRise", 32'(bus.state_dbg), 32'd0);
        tick();

        // Read back 0x2A
        bus.cs = 1'b0;
        tick();
        checkOutput("rdCsFall", 32'(bus.state_dbg), 32'd1);
        pushExp(1'b0, 7'h2A, 8'hC3);
        sendByte(8'h55);
        checkOutput("rdDecode", 32'(bus.state_dbg), 32'd2);
        tick();
        checkOutput("rdLoadState", 32'(bus.state_dbg), 32'd3);
        checkOutput("rdLoadSrWe",  32'(bus.sr_we), 32'd1);
        checkOutput("rdLoadBufe",  32'(bus.miso_bufe), 32'd1);
        checkOutput("rdLoadAddr",  32'(bus.addr), 32'h2A);
        tick();
        checkOutput("rdShiftState", 32'(bus.state_dbg), 32'd4);
        checkOutput("rdShiftSrWe",  32'(bus.sr_we), 32'd0);
        misoByte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checkOutput("rdBitBufe", 32'(bus.miso_bufe), 32'd1);
`ifdef SPI_BURST_EN
            if (i == 7) pushExp(1'b0, 7'h2B, 8'h00);
`endif
            misoByte = {misoByte[6:0], loadedByte[7-i]};
            applyStimulus(1'b0);
        end
        checkOutput("rdMisoByte", 32'(misoByte), 32'hC3);
`ifdef SPI_BURST_EN
        checkOutput("rdEndState", 32'(bus.state_dbg), 32'd3);
        checkOutput("rdEndBufe",  32'(bus.miso_bufe), 32'd1);
        checkOutput("rdEndAddr",  32'(bus.addr), 32'h2B);
`else
        checkOutput("rdEndState", 32'(bus.state_dbg), 32'd7);
        checkOutput("rdEndBufe",  32'(bus.miso_bufe), 32'd0);
        checkOutput("rdEndAddr",  32'(bus.addr), 32'h2A);
`endif
        bus.cs = 1'b1;
        tick();
        checkOutput("rdCsRiseState", 32'(bus.state_dbg), 32'd0);
        checkOutput("rdCsRiseBufe",  32'(bus.miso_bufe), 32'd0);
        tick();

        // Aborted write: cs rises after 4 data bits
        bus.cs = 1'b0;
        tick();
        sendByte(8'h54);
        tick();
        checkOutput("abGetState", 32'(bus.state_dbg), 32'd5);
        pat = 8'h99;
        for (int i = 7; i >= 4; i--) applyStimulus(pat[i]);
        bus.cs = 1'b1;
        tick();
        checkOutput("abState", 32'(bus.state_dbg), 32'd0);
        checkOutput("abDmWe",  32'(bus.dm_we), 32'd0);
        repeat (3) tick();
        checkOutput("abMemKept", 32'(mem[7'h2A]), 32'hC3);

        // Asynchronous reset in the middle of a read
        bus.cs = 1'b0;
        tick();
        pushExp(1'b0, 7'h2A, 8'hC3);
        sendByte(8'h55);
        tick();
        tick();
        checkOutput("rmShiftState", 32'(bus.state_dbg), 32'd4);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rmState", 32'(bus.state_dbg), 32'd0);
        checkOutput("rmAddr",  32'(bus.addr), 32'd0);
        checkOutput("rmBufe",  32'(bus.miso_bufe), 32'd0);
        checkOutput("rmSrWe",  32'(bus.sr_we), 32'd0);
        checkOutput("rmDmWe",  32'(bus.dm_we), 32'd0);
        bus.cs = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Write two bytes at 0x7F: burst wraps to 0x00, single mode ignores byte two
        bus.cs = 1'b0;
        tick();
        sendByte(8'hFE);
        checkOutput("bwDecode", 32'(bus.state_dbg), 32'd2);
        tick();
        checkOutput("bwGetAddr", 32'(bus.addr), 32'h7F);
        pushExp(1'b1, 7'h7F, 8'h11);
        sendByte(8'h11);
        checkOutput("bwStore1State", 32'(bus.state_dbg), 32'd6);
        checkOutput("bwStore1Addr",  32'(bus.addr), 32'h7F);
`ifdef SPI_BURST_EN
        pushExp(1'b1, 7'h00, 8'h22);
        tick();
        checkOutput("bwWrapState", 32'(bus.state_dbg), 32'd5);
        checkOutput("bwWrapAddr",  32'(bus.addr), 32'h00);
        sendByte(8'h22);
        checkOutput("bwStore2State", 32'(bus.state_dbg), 32'd6);
        checkOutput("bwStore2Addr",  32'(bus.addr), 32'h00);
        tick();
        checkOutput("bwAfterState", 32'(bus.state_dbg), 32'd5);
`else
        tick();
        checkOutput("bwDoneState", 32'(bus.state_dbg), 32'd7);
        sendByte(8'h22);
        checkOutput("bwIgnoredState", 32'(bus.state_dbg), 32'd7);
        checkOutput("bwIgnoredDmWe",  32'(bus.dm_we), 32'd0);
        checkOutput("bwIgnoredAddr",  32'(bus.addr), 32'h7F);
`endif
        bus.cs = 1'b1;
        tick();
        checkOutput("bwCsRise", 32'(bus.state_dbg), 32'd0);
        repeat (2) tick();

        checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_txn_controller.md
# spi_txn_controller

Transaction sequencer for the SPI memory slave. Consumes the conditioned SCLK edge pulses and chip select, counts bits, and drives the load/write/enable strobes of the shift register, data memory and MISO tri-state buffer. Owns the 7-bit memory address register, replacing the separate address latch. Optionally streams consecutive bytes (burst) within one chip-select window.

## Interface
Parameters:
- ADDR_W, 7, memory address width; the address field occupies shift register bits [7:1].

Ports:
- clk  input  1  FPGA clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; forces the reset state immediately
- sclk_posedge  input  1  one-clk pulse per conditioned SCLK rising edge
- cs  input  1  conditioned chip select, active-low
- sr_pout  input  8  shift register parallel output; bit 0 is the R/W flag (1 = read)
- addr  output  ADDR_W  current memory address
- sr_we  output  1  shift register parallel-load strobe
- dm_we  output  1  data memory write strobe
- miso_bufe  output  1  MISO buffer enable
- state_dbg  output  4  current state encoding, for the LEDs

## Operation
- Frame: 8 address/R-W bits, MSB first, then 8 data bits. Address = sr_pout[7:1] and R/W = sr_pout[0], sampled after the 8th bit.
- 3-bit counter bit_cnt increments on sclk_posedge in GET_ADDR, READ_SHIFT and WRITE_GET only. A phase ends on the posedge that wraps bit_cnt from 7 to 0.
- States (state_dbg value):
  - IDLE (0): all strobes 0, bit_cnt = 0. cs low -> GET_ADDR.
  - GET_ADDR (1): 8th posedge -> DECODE.
  - DECODE (2): one clk. addr <= sr_pout[7:1]. sr_pout[0] = 1 -> READ_LOAD, else -> WRITE_GET.
  - READ_LOAD (3): one clk. sr_we = 1, miso_bufe = 1 -> READ_SHIFT.
  - READ_SHIFT (4): miso_bufe = 1. 8th posedge -> DONE (burst: addr+1, -> READ_LOAD).
  - WRITE_GET (5): 8th posedge -> WRITE_STORE.
  - WRITE_STORE (6): one clk. dm_we = 1 at the current addr. -> DONE (burst: addr+1 after the store, -> WRITE_GET).
  - DONE (7): strobes 0. Further posedges are ignored. Waits for cs high.
- cs high in any state -> IDLE on the next clk. This takes priority over a simultaneous sclk_posedge and over single-cycle states. An aborted write never asserts dm_we.
- Address increment wraps modulo 2^ADDR_W (127 -> 0).
- A sclk_posedge arriving in a single-cycle state (DECODE, READ_LOAD, WRITE_STORE) is not counted. The input conditioner spacing guarantees at least 3 clk between SCLK edges, so this never occurs in legal operation.
- sr_we, dm_we and miso_bufe are registered, decoded from the state register; no combinational path exists from any input to any output.

## Timing
- Reset values: state IDLE, bit_cnt 0, addr 0, sr_we 0, dm_we 0, miso_bufe 0, state_dbg 0.
- cs falls -> GET_ADDR one clk later.
- 8th address posedge -> DECODE next clk. addr is valid one clk after that, together with the sr_we pulse (read) or entry to WRITE_GET (write).
- The data memory read is combinational, so sr_we in READ_LOAD loads the byte at the new addr. This completes at least 2 clk before the next SCLK falling edge.
- 8th write-data posedge -> dm_we high for exactly one clk, starting the next clk.
- miso_bufe rises with sr_we and falls on the clk after the 8th read posedge (non-burst) or on cs high.

## Configuration
- SPI_BURST_EN defined: after each data byte, addr increments and the transfer continues with the next byte in the same direction until cs rises.
- SPI_BURST_EN undefined: exactly one data byte per cs window; the controller enters DONE and addr is never incremented.

## Test plan
- Write: cs low, shift 0x54 (addr 0x2A, W), then 0xC3 -> dm_we one clk with addr = 0x2A, sr_pout = 0xC3. Then DONE, state_dbg = 7.
- Read: after the write above, shift 0x55 (addr 0x2A, R) -> sr_we one clk with addr = 0x2A. miso_bufe high for 8 posedges. MISO yields 0xC3.
- Abort: cs high after the 4th write-data bit -> state IDLE next clk, dm_we never asserted, memory at 0x2A unchanged.
- Reset mid-read: assert reset during READ_SHIFT -> all outputs 0 and addr 0 immediately, without waiting for clk.
- Burst (SPI_BURST_EN): write at addr 0x7F with bytes 0x11, 0x22 -> dm_we at addr 0x7F, then at 0x00 (wrap).
- Burst disabled: same stimulus -> one dm_we only, at 0x7F. The second byte is ignored and state_dbg stays 7 until cs high.
